vga_layer_mixer: RTL and testbench

- Parametrised pixel compositor for the VGA output path.
- Takes NUM_LAYERS hit/colour pairs from the ball, paddle and future sprite generators and resolves them by fixed priority over a background colour.
- Applies a frame-synchronous win-sequence effect (flash, then dim hold) and drives registered RGB plus delay-matched syncs to the DAC pins.
- Sits between the sync generator / object generators and the top-level VGA pins.

---
 rtl/vga_layer_mixer.sv | 211 +++++++++++++++++++++
 tb/tb_vga_layer_mixer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_mixer.sv
// Priority layer compositor with frame-synchronous win effects.
// Define VGA_MIXER_BORDER_EN to add hsp/vsp ports and a white playfield border.
module vga_layer_mixer #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 4,
  parameter int FLASH_FRAMES = 120,
  parameter int BLINK_FRAMES = 15
) (
  input  logic                           vga_clk,
  input  logic                           rst,
  input  logic                           hs_in,
  input  logic                           vs_in,
  input  logic                           disparea,
  input  logic [NUM_LAYERS-1:0]          layer_hit,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [3*COLOR_W-1:0]           bg_rgb,
`ifdef VGA_MIXER_BORDER_EN
  input  logic [9:0]                     hsp,
  input  logic [9:0]                     vsp,
`endif
  input  logic                           win_in,
  input  logic                           clear,
  output logic [COLOR_W-1:0]             vga_r,
  output logic [COLOR_W-1:0]             vga_g,
  output logic [COLOR_W-1:0]             vga_b,
  output logic                           hs_out,
  output logic                           vs_out,
  output logic                           frame_tick,
  output logic                           overlap,
  output logic [1:0]                     mode
);

  localparam int PW = 3 * COLOR_W;
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FLASH  = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state, state_n;
  logic [7:0] frame_cnt, frame_n;
  logic [7:0] blink_cnt, blink_n;
  logic       phase, phase_n;

  logic                            hs1, vs1, de1;
  logic [NUM_LAYERS-1:0]           hit1;
  logic [NUM_LAYERS*PW-1:0]        rgb1;
  logic [PW-1:0]                   bg1;
  logic                            vs_prev, armed;
  logic                            win_q, pend_win, pend_clr;
  logic                            vs_fall;

`ifdef VGA_MIXER_BORDER_EN
  logic [9:0] hsp1, vsp1;
  logic       border1;
  assign border1 = (hsp1 < 10'd4) || (hsp1 > 10'd635) ||
                   (vsp1 < 10'd4) || (vsp1 > 10'd475);
`endif

  // Stage 1: capture every per-pixel input together.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      de1  <= 1'b0;
      hit1 <= '0;
      rgb1 <= '0;
      bg1  <= '0;
`ifdef VGA_MIXER_BORDER_EN
      hsp1 <= '0;
      vsp1 <= '0;
`endif
    end else begin
      hs1  <= hs_in;
      vs1  <= vs_in;
      de1  <= disparea;
      hit1 <= layer_hit;
      rgb1 <= layer_rgb;
      bg1  <= bg_rgb;
`ifdef VGA_MIXER_BORDER_EN
      hsp1 <= hsp;
      vsp1 <= vsp;
`endif
    end
  end

  // vs_prev only tracks real samples, so the reset value of vs1 never forms an edge.
  assign vs_fall = vs_prev & ~vs1;

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
      win_q      <= 1'b0;
      pend_win   <= 1'b0;
      pend_clr   <= 1'b0;
    end else begin
      armed      <= 1'b1;
      vs_prev    <= armed ? vs1 : 1'b0;
      frame_tick <= vs_fall;
      win_q      <= win_in;
      pend_win   <= (win_in & ~win_q) | (pend_win & ~frame_tick);
      pend_clr   <= clear | (pend_clr & ~frame_tick);
    end
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      state     <= NORMAL;
      frame_cnt <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      blink_cnt <= blink_n;
      phase     <= phase_n;
    end
  end

  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    blink_n = blink_cnt;
    phase_n = phase;
    if (frame_tick) begin
      unique case (state)
        NORMAL: begin
          if (pend_win && !pend_clr) begin
            state_n = FLASH;
            frame_n = '0;
            blink_n = '0;
            phase_n = 1'b0;
          end
        end
        FLASH: begin
          if (pend_clr) begin
            state_n = NORMAL;
          end else begin
            if (frame_cnt == FLASH_LAST) state_n = HOLD;
            else frame_n = frame_cnt + 8'd1;
            if (blink_cnt == BLINK_LAST) begin
              blink_n = '0;
              phase_n = ~phase;
            end else begin
              blink_n = blink_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (pend_clr) state_n = NORMAL;
        end
        default: state_n = NORMAL;
      endcase
    end
  end

  // Stage 2: priority select (lowest index wins), then the mode effect.
  logic [PW-1:0] sel, dim, pix;
  logic          is_bg;

  always_comb begin
    sel   = bg1;
    is_bg = 1'b1;
`ifdef VGA_MIXER_BORDER_EN
    if (border1) begin
      sel   = '1;
      is_bg = 1'b0;
    end
`endif
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        sel   = rgb1[i*PW +: PW];
        is_bg = 1'b0;
      end
    end
    dim = '0;
    for (int c = 0; c < 3; c++) begin
      dim[c*COLOR_W +: COLOR_W] = sel[c*COLOR_W +: COLOR_W] >> 1;
    end
    pix = sel;
    if (!de1) pix = '0;
    else if (state == FLASH && phase) pix = ~sel;
    else if (state == HOLD && is_bg) pix = dim;
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
      hs_out  <= 1'b1;
      vs_out  <= 1'b1;
      overlap <= 1'b0;
    end else begin
      vga_r   <= pix[2*COLOR_W +: COLOR_W];
      vga_g   <= pix[COLOR_W +: COLOR_W];
      vga_b   <= pix[0 +: COLOR_W];
      hs_out  <= hs1;
      vs_out  <= vs1;
      overlap <= de1 & (|(hit1 & (hit1 - NUM_LAYERS'(1))));
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: priority, blanking, latency,
// win/clear sequencing and asynchronous reset.
module tb_vga_layer_mixer;
  localparam int NL = 4;
  localparam int CW = 4;

  logic vga_clk = 1'b0;
  logic rst = 1'b0;
  logic hs_in = 1'b1;
  logic vs_in = 1'b1;
  logic disparea = 1'b0;
  logic win_in = 1'b0;
  logic clear = 1'b0;
  logic [NL-1:0] layer_hit = '0;
  logic [NL*3*CW-1:0] layer_rgb = '0;
  logic [3*CW-1:0] bg_rgb = '0;
`ifdef VGA_MIXER_BORDER_EN
  logic [9:0] hsp = 10'd300;
  logic [9:0] vsp = 10'd200;
`endif
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic hs_out, vs_out, frame_tick, overlap;
  logic [1:0] mode;
  logic [11:0] rgb;

  int tests = 0;
  int fails = 0;
  int ticks;

  assign rgb = {vga_r, vga_g, vga_b};

  vga_layer_mixer #(
    .NUM_LAYERS(NL),
    .COLOR_W(CW),
    .FLASH_FRAMES(4),
    .BLINK_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk),
    .rst(rst),
    .hs_in(hs_in),
    .vs_in(vs_in),
    .disparea(disparea),
    .layer_hit(layer_hit),
    .layer_rgb(layer_rgb),
    .bg_rgb(bg_rgb),
`ifdef VGA_MIXER_BORDER_EN
    .hsp(hsp),
    .vsp(vsp),
`endif
    .win_in(win_in),
    .clear(clear),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .hs_out(hs_out),
    .vs_out(vs_out),
    .frame_tick(frame_tick),
    .overlap(overlap),
    .mode(mode)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    vs_in = 1'b0;
    step(4);
    vs_in = 1'b1;
    step(4);
  endtask

  initial begin
    step(3);
    check("rst_rgb", rgb, 12'h000);
    check("rst_hs", hs_out, 1);
    check("rst_vs", vs_out, 1);
    check("rst_mode", mode, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_ovl", overlap, 0);

    rst = 1'b1;
    layer_rgb = {12'hFFF, 12'h0F0, 12'hF00, 12'h00F};
    bg_rgb = 12'h123;
    disparea = 1'b1;
    layer_hit = 4'b0110;
    step(2);
    check("prio_0110", rgb, 12'hF00);
    check("ovl_0110", overlap, 1);
    layer_hit = 4'b0100;
    step(2);
    check("prio_0100", rgb, 12'h0F0);
    check("ovl_0100", overlap, 0);
    layer_hit = 4'b0000;
    step(2);
    check("prio_bg", rgb, 12'h123);
    layer_hit = 4'b1000;
    step(2);
    check("prio_1000", rgb, 12'hFFF);
    layer_hit = 4'b1111;
    step(2);
    check("prio_1111", rgb, 12'h00F);

    disparea = 1'b0;
    layer_hit = 4'b0001;
    step(2);
    check("blank_rgb", rgb, 12'h000);
    layer_hit = 4'b0011;
    step(2);
    check("blank_ovl", overlap, 0);

    disparea = 1'b1;
    layer_hit = 4'b0000;
    hs_in = 1'b0;
    step(1);
    check("hs_lat1", hs_out, 1);
    step(1);
    check("hs_lat2", hs_out, 0);
    hs_in = 1'b1;
    step(2);

    vs_in = 1'b0;
    step(1);
    check("tick_c1", frame_tick, 0);
    step(1);
    check("tick_c2", frame_tick, 1);
    step(1);
    check("tick_c3", frame_tick, 0);
    vs_in = 1'b1;
    step(4);
    check("normal_mode", mode, 0);

    win_in = 1'b1;
    step(1);
    win_in = 1'b0;
    step(3);
    check("win_pending", mode, 0);
    frame();
    check("flash_f1_mode", mode, 1);
    check("flash_f1_rgb", rgb, 12'h123);
    frame();
    check("flash_f2_rgb", rgb, 12'h123);
    frame();
    check("flash_f3_rgb", rgb, 12'hEDC);
    layer_hit = 4'b0001;
    step(2);
    check("flash_f3_layer", rgb, 12'hFF0);
    layer_hit = 4'b0000;
    frame();
    check("flash_f4_mode", mode, 1);
    check("flash_f4_rgb", rgb, 12'hEDC);
    frame();
    check("hold_mode", mode, 2);
    check("hold_bg", rgb, 12'h011);
    layer_hit = 4'b0001;
    step(2);
    check("hold_layer", rgb, 12'h00F);
    layer_hit = 4'b0000;

    win_in = 1'b1;
    frame();
    check("hold_win_ign", mode, 2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    frame();
    check("hold_clear", mode, 0);
    check("normal_rgb", rgb, 12'h123);
    frame();
    check("no_retrigger", mode, 0);
    win_in = 1'b0;
    step(2);

    win_in = 1'b1;
    clear = 1'b1;
    step(1);
    win_in = 1'b0;
    clear = 1'b0;
    frame();
    check("clr_prec_1", mode, 0);
    frame();
    check("clr_prec_2", mode, 0);

    win_in = 1'b1;
    step(1);
    win_in = 1'b0;
    frame();
    check("reflash_mode", mode, 1);
    hs_in = 1'b0;
    vs_in = 1'b0;
    step(2);
    check("pre_rst_hs", hs_out, 0);
    check("pre_rst_rgb", rgb, 12'h123);
    rst = 1'b0;
    #1;
    check("arst_mode", mode, 0);
    check("arst_rgb", rgb, 12'h000);
    check("arst_hs", hs_out, 1);
    check("arst_vs", vs_out, 1);
    step(2);
    rst = 1'b1;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (frame_tick) ticks++;
    end
    check("no_false_tick", ticks, 0);
    hs_in = 1'b1;
    vs_in = 1'b1;
    step(3);
    vs_in = 1'b0;
    step(2);
    check("real_tick", frame_tick, 1);
    vs_in = 1'b1;
    step(4);
    check("post_rst_mode", mode, 0);

`ifdef VGA_MIXER_BORDER_EN
    hsp = 10'd2;
    vsp = 10'd100;
    layer_hit = 4'b0000;
    step(2);
    check("border_white", rgb, 12'hFFF);
    layer_hit = 4'b0001;
    step(2);
    check("border_layer", rgb, 12'h00F);
    hsp = 10'd300;
    vsp = 10'd200;
    layer_hit = 4'b0000;
    step(2);
    check("border_off", rgb, 12'h123);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
